// File: rtl/paralelo_serial_param.sv
// paralelo_serial_param: parallel-to-serial converter with an input FIFO.
// Words are shifted out one bit per clk_32f. When no word is waiting at a
// symbol boundary, the IDLE filler symbol is sent and counted.
module paralelo_serial_param #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE     = WIDTH'(8'hBC),
  parameter int              MSB_FIRST = 1,
  parameter int              DEPTH     = 4
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic                     data_out,
  output logic                     sym_start,
  output logic                     idle_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               idle_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             idle_flag;
  logic [7:0]       idle_sat;

  logic boundary;
  logic push;
  logic pop;

  // A boundary pops only words that were already stored before this edge,
  // so a word written on the boundary edge waits for the next symbol.
  assign boundary = (bit_cnt == LAST_BIT);
  assign push     = valid_in && ready_out;
  assign pop      = boundary && (count != '0);

  assign ready_out  = (count < FULL_COUNT);
  assign sym_start  = (bit_cnt == '0);
  assign data_out   = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
  assign idle_out   = idle_flag;
  assign fifo_count = count;
  assign idle_cnt   = idle_sat;

  // Bit position within the current symbol, wrapping at the symbol boundary.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (boundary) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift register: loads a stored word or IDLE at each boundary, shifts otherwise.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shift_reg <= IDLE;
      idle_flag <= 1'b1;
      idle_sat  <= 8'd0;
    end else if (boundary) begin
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        idle_flag <= 1'b0;
      end else begin
        shift_reg <= IDLE;
        idle_flag <= 1'b1;
        if (idle_sat != 8'hFF) begin
          idle_sat <= idle_sat + 1'b1;
        end
      end
    end else if (MSB_FIRST != 0) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
    end else begin
      shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; reset only needs to clear the pointers, not the contents.
  always_ff @(posedge clk_32f) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// tb_paralelo_serial_param: directed scoreboard bench for paralelo_serial_param.
module tb_paralelo_serial_param;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, sym_start, idle_out;
  logic [2:0] fifo_count;
  logic [7:0] idle_cnt;

  logic [7:0] l_data_in = 8'h00;
  logic       l_valid_in = 1'b0;
  logic       l_ready_out, l_data_out, l_sym_start, l_idle_out;
  logic [2:0] l_fifo_count;
  logic [7:0] l_idle_cnt;

  int n_compared = 0;
  int n_failed   = 0;
  int n_data_syms = 0;
  int n_idle_syms = 0;

  logic [7:0] exp_q [$];
  bit         saw_full = 1'b0;

  bit         mon_active = 1'b0;
  int         mon_bits = 0;
  logic [7:0] mon_sym = 8'h00;
  logic       mon_idle = 1'b0;

  paralelo_serial_param dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .sym_start  (sym_start),
    .idle_out   (idle_out),
    .fifo_count (fifo_count),
    .idle_cnt   (idle_cnt)
  );

  paralelo_serial_param #(.MSB_FIRST(0)) dut_lsb (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (l_data_in),
    .valid_in   (l_valid_in),
    .ready_out  (l_ready_out),
    .data_out   (l_data_out),
    .sym_start  (l_sym_start),
    .idle_out   (l_idle_out),
    .fifo_count (l_fifo_count),
    .idle_cnt   (l_idle_cnt)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Serial monitor: rebuilds each symbol and checks it against IDLE or the scoreboard.
  always @(negedge clk_32f) begin
    if (reset) begin
      mon_active = 1'b0;
      mon_bits   = 0;
    end else begin
      if (mon_active) begin
        check("sym_start_spacing", sym_start, mon_bits == 8);
        if (mon_bits == 8) begin
          if (mon_idle) begin
            check("idle_symbol", mon_sym, 8'hBC);
            n_idle_syms++;
          end else begin
            check("data_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("data_symbol", mon_sym, exp_q.pop_front());
            n_data_syms++;
          end
          mon_active = 1'b0;
        end
      end
      if (sym_start) begin
        mon_active = 1'b1;
        mon_bits   = 0;
        mon_idle   = idle_out;
      end
      if (mon_active) begin
        mon_sym = {mon_sym[6:0], data_out};
        mon_bits++;
      end
    end
  end

  task automatic drive_word(input logic [7:0] w);
    int waited = 0;
    valid_in = 1'b1;
    data_in  = w;
    check("count_bound", fifo_count <= 3'd4, 1);
    while (!ready_out && waited < 200) begin
      check("full_when_stalled", fifo_count, 4);
      saw_full = 1'b1;
      @(negedge clk_32f);
      waited++;
    end
    check("accept_timeout", waited < 200, 1);
    if (waited < 200) begin
      exp_q.push_back(w);
      @(negedge clk_32f);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    #2;
    reset      = 1'b1;
    valid_in   = 1'b0;
    l_valid_in = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_32f);
    #2 reset = 1'b0;
    @(negedge clk_32f);
  endtask

  initial begin
    int pulses;
    int n0;
    int waited;
    logic lsb_bits [8];
    lsb_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset applied before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_fifo_count", fifo_count, 0);
    check("rst_idle_cnt", idle_cnt, 0);
    check("rst_ready", ready_out, 1);
    check("rst_sym_start", sym_start, 1);
    check("rst_idle_out", idle_out, 1);
    check("rst_data_out_msb", data_out, 1);
    check("rst_data_out_lsb", l_data_out, 0);
    @(posedge clk_32f);
    @(posedge clk_32f);
    #2 reset = 1'b0;
    @(negedge clk_32f);

    // Idle stream only
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk_32f);
      if (sym_start) pulses++;
    end
    check("idle_pulses_24", pulses, 3);
    check("idle_cnt_24", idle_cnt, 2);

    // AB accepted at bit 6, then CA and 12 back to back
    do_reset();
    repeat (6) @(negedge clk_32f);
    drive_word(8'hAB);
    drive_word(8'hCA);
    check("latency_sym_start", sym_start, 1);
    check("latency_idle_out", idle_out, 0);
    check("latency_first_bit", data_out, 1);
    check("push_pop_count", fifo_count, 1);
    drive_word(8'h12);
    valid_in = 1'b0;
    check("two_queued", fifo_count, 2);
    n0 = n_data_syms;
    repeat (60) @(negedge clk_32f);
    #1;
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_data_syms", n_data_syms - n0, 3);
    check("b2b_idle_after", idle_out, 1);
    check("b2b_empty", fifo_count, 0);

    // Backpressure with eight words
    n0 = n_data_syms;
    saw_full = 1'b0;
    for (int w = 1; w <= 8; w++) drive_word(8'(w));
    valid_in = 1'b0;
    check("saw_full", saw_full, 1);
    repeat (100) @(negedge clk_32f);
    #1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_data_syms", n_data_syms - n0, 8);
    check("bp_empty", fifo_count, 0);

    // Reset in the middle of AB with two words queued
    do_reset();
    repeat (6) @(negedge clk_32f);
    drive_word(8'hAB);
    drive_word(8'hCA);
    drive_word(8'h12);
    valid_in = 1'b0;
    @(negedge clk_32f);
    @(negedge clk_32f);
    check("mid_ab_bit4", data_out, 0);
    check("mid_ab_queued", fifo_count, 2);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_data_out", data_out, 1);
    check("async_fifo_count", fifo_count, 0);
    check("async_ready", ready_out, 1);
    check("async_sym_start", sym_start, 1);
    check("async_idle_out", idle_out, 1);
    repeat (2) @(posedge clk_32f);
    #2 reset = 1'b0;
    @(negedge clk_32f);
    n0 = n_data_syms;
    repeat (40) @(negedge clk_32f);
    #1;
    check("abort_no_data", n_data_syms - n0, 0);
    check("abort_idle_out", idle_out, 1);
    check("abort_idle_cnt", idle_cnt, 5);

    // Idle counter saturation
    do_reset();
    repeat (2039) @(negedge clk_32f);
    check("idle_cnt_254", idle_cnt, 254);
    @(negedge clk_32f);
    check("idle_cnt_255", idle_cnt, 255);
    repeat (400) @(negedge clk_32f);
    check("idle_cnt_held", idle_cnt, 255);

    // LSB-first instance sends A5
    @(negedge clk_32f);
    check("lsb_ready", l_ready_out, 1);
    l_data_in  = 8'hA5;
    l_valid_in = 1'b1;
    @(negedge clk_32f);
    l_valid_in = 1'b0;
    waited = 0;
    while (!(l_sym_start && !l_idle_out) && waited < 40) begin
      @(negedge clk_32f);
      waited++;
    end
    check("lsb_timeout", waited < 40, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb_bit%0d", i), l_data_out, lsb_bits[i]);
      @(negedge clk_32f);
    end

    #1;
    check("idle_syms_seen", n_idle_syms >= 300, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_param.md
PARALELO_SERIAL_PARAM -- requirements
Module: paralelo_serial_param

Interface
REQ-001 Parameter WIDTH, default 8: symbol width in bits; the legal range is 2 to 32.
REQ-002 Parameter IDLE, default 8'hBC (WIDTH bits): symbol sent when no data is pending.
REQ-003 Parameter MSB_FIRST, default 1: 1 sends MSB first; 0 sends LSB first.
REQ-004 Parameter DEPTH, default 4: input FIFO depth; it must be a power of 2 and at least 2.
REQ-005 clk_32f  input  1  the single clock (bit clock); all logic is rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  WIDTH  parallel word to serialise.
REQ-008 valid_in  input  1  data_in is valid.
REQ-009 ready_out  output  1  the FIFO can accept a word this cycle.
REQ-010 data_out  output  1  serial bit stream, one bit per clk_32f.
REQ-011 sym_start  output  1  high during the first bit of every symbol.
REQ-012 idle_out  output  1  the symbol currently on data_out is IDLE filler.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  number of words stored in the FIFO.
REQ-014 idle_cnt  output  8  number of IDLE symbols inserted; it saturates at 255.

Function
REQ-015 A write occurs when valid_in and ready_out are both 1 at a clock edge; ready_out shall equal (fifo_count < DEPTH).
REQ-016 While valid_in=1 and ready_out=0, the word shall not be accepted and shall not be lost; the source holds it.
REQ-017 A bit counter shall count 0..WIDTH-1 and wrap to 0; sym_start shall equal (bit counter == 0).
REQ-018 A symbol boundary is the edge at which the bit counter equals WIDTH-1; the shift register loads the next symbol at that edge.
REQ-019 At a boundary, if fifo_count > 0 before the edge, the oldest word shall be popped and loaded, and idle_out shall be cleared.
REQ-020 Otherwise, IDLE shall be loaded, idle_out shall be set, and idle_cnt shall increment unless it is already 255.
REQ-021 A word accepted on the same edge as a boundary shall not be loaded at that boundary; it waits for the next one.
REQ-022 A simultaneous push and pop shall leave fifo_count unchanged, and the FIFO pointers shall wrap modulo DEPTH.
REQ-023 data_out shall be the shift-register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0); it is registered with no combinational path from the inputs.
REQ-024 Between boundaries, the shift register shall shift by one position per clock.
REQ-025 Latency: a word accepted at the edge where the bit counter is WIDTH-2, with an empty FIFO, shall have its first bit on data_out in the next cycle that has sym_start=1.
REQ-026 Words shall leave in acceptance order, each exactly once.
REQ-027 Symbols shall be contiguous: there are no gap bits between symbols, and a partial symbol is never emitted except when aborted by reset.

Reset
REQ-028 Reset shall act asynchronously, with no clock required for it to take effect.
REQ-029 While reset=1: bit counter=0, shift register=IDLE, FIFO empty, fifo_count=0, idle_cnt=0, ready_out=1, sym_start=1, idle_out=1, and data_out=IDLE MSB (MSB_FIRST=1) or IDLE LSB (MSB_FIRST=0).
REQ-030 Reset asserted mid-symbol shall abort the symbol and discard all FIFO contents.
REQ-031 After reset deasserts, the first full symbol shall be IDLE (the reset-value symbol), and it shall not be counted in idle_cnt.

Verification (WIDTH=8, IDLE=BC, DEPTH=4 unless stated)
REQ-032 No valid_in after reset -> data_out repeats 1,0,1,1,1,1,0,0; sym_start pulses every 8 cycles; idle_cnt=2 after 24 cycles.
REQ-033 Words AB, CA, 12 written back-to-back after reset -> serial stream BC, AB, CA, 12, BC, ...; idle_out=0 only during the three data symbols.
REQ-034 valid_in held high for 8 words 01..08 -> ready_out=0 whenever fifo_count=4; the output order is 01..08 with no loss or duplicates; fifo_count never exceeds 4.
REQ-035 Reset pulsed after the 3rd bit of AB with 2 words queued -> data_out=1 immediately, fifo_count=0, and the next symbols are BC.
REQ-036 MSB_FIRST=0, word A5 -> bits 1,0,1,0,0,1,0,1.
REQ-037 300 idle boundaries -> idle_cnt=255 and held there.
